priority_encoder_42: RTL

Sequential 4-to-2 priority encoder with request capture and a valid/ready output handshake. It is the inverse of the codebase's 2-to-4 decoder: one-hot or multi-hot request pulses on `w` are latched as pending, then emitted one at a time as binary indices on `out`. Every pending request is eventually reported exactly once, highest index first. It sits between event sources (for example, per-line strobes) and any consumer that needs encoded indices.

---
 rtl/priority_encoder_42.sv | 125 ++++++++++++
 1 files changed

// File: rtl/priority_encoder_42.sv
// priority_encoder_42
//   Sequential N-to-W priority encoder with request capture and a
//   valid/ready output handshake. Request pulses on w are latched into
//   a pending set. Pending requests are then offered one at a time on
//   out, highest index first, and each request is reported exactly once.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   EN        in   capture enable; w is ignored while low
//   w         in   [N-1:0] request pulses, bit i = request for index i
//   ready     in   consumer accepts out this cycle
//   out       out  [W-1:0] index being offered
//   valid     out  out holds an unconsumed index
//   pending   out  [N-1:0] captured requests not yet offered
//   overflow  out  sticky: a request arrived for an already-pending bit

module priority_encoder_42 #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         EN,
    input  logic [N-1:0] w,
    input  logic         ready,
    output logic [W-1:0] out,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic         overflow
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [W-1:0] sel;
    logic         has_pending;
    logic         load;
    logic [N-1:0] sel_mask;
    logic [N-1:0] capture;
    logic [N-1:0] pending_next;
    logic         overflow_set;

    // Highest set bit of the registered pending set. Requests arriving on
    // this edge are not yet in the register, so they cannot be selected.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pending[i]) begin
                sel = W'(i);
            end
        end
    end

    assign has_pending = |pending;
    assign capture     = EN ? w : '0;

    // Next-state and output-slot load decision.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (has_pending) begin
                    load       = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (has_pending) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        sel_mask = '0;
        if (load) begin
            sel_mask[sel] = 1'b1;
        end
    end

    // Capture is OR'ed in after the selection clear, so a bit that is
    // both selected and re-requested on the same edge stays pending.
    assign pending_next = (pending & ~sel_mask) | capture;

    // A re-request of the bit moving into out is not lost, so it is
    // excluded from the overflow condition.
    assign overflow_set = |(capture & pending & ~sel_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            out      <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            if (load) begin
                out <= sel;
            end
            if (overflow_set) begin
                overflow <= 1'b1;
            end
        end
    end

    // Decoded straight from the state flop, so still free of any
    // combinational path from the inputs.
    assign valid = (state == HOLD);

endmodule
